// File: rtl/demux_reg_pkg.sv
// Shared defaults and the queued write-request record for the demux register
// block and its write queue.
package demux_reg_pkg;

    localparam int DEFAULT_WIDTH  = 5;
    localparam int DEFAULT_WID    = 32;
    localparam int DEFAULT_QDEPTH = 4;

    typedef struct packed {
        logic [DEFAULT_WIDTH-1:0] index;
        logic [DEFAULT_WID-1:0]   data;
    } wr_req_t;

endpackage

// File: rtl/demux_reg_wr_fifo.sv
// Small FIFO of write requests; the head is presented combinationally so a
// request can commit on the edge right after it is pushed.
module wr_fifo
    import demux_reg_pkg::*;
#(
    parameter int  QDEPTH = DEFAULT_QDEPTH,
    parameter type T      = wr_req_t
) (
    input  logic clk,
    input  logic srst,
    input  logic flush,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output T     pop_data,
    output logic full,
    output logic empty
);

    localparam int PW = $clog2(QDEPTH);

    T               mem_reg [QDEPTH];
    logic [PW-1:0]  wr_ptr_reg;
    logic [PW-1:0]  rd_ptr_reg;
    logic [PW:0]    count_reg;
    logic           push_ok;
    logic           pop_ok;

    assign full     = (count_reg == (PW+1)'(QDEPTH));
    assign empty    = (count_reg == '0);
    assign push_ok  = push & ~full;
    assign pop_ok   = pop & ~empty;
    assign pop_data = mem_reg[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    // QDEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (srst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (PW+1)'(1);
                2'b01:   count_reg <= count_reg - (PW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/demux_reg.sv
// Register bank written through a short request queue: one queued write is
// committed per cycle, with a registered done/error pulse per commit.
module demux_reg
    import demux_reg_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int WID    = DEFAULT_WID,
    parameter int DEPTH  = 1 << WIDTH,
    parameter int QDEPTH = DEFAULT_QDEPTH
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [WIDTH-1:0]          index_i,
    input  logic [WID-1:0]            data_i,
    input  logic                      write_en_i,
    output logic                      write_ready_o,
    input  logic                      clear_i,
    output logic [DEPTH-1:0][WID-1:0] data_o,
    output logic [DEPTH-1:0]          valid_o,
    output logic                      write_done_o,
    output logic [WIDTH-1:0]          done_index_o,
    output logic                      write_err_o
);

    typedef struct packed {
        logic [WIDTH-1:0] index;
        logic [WID-1:0]   data;
    } req_t;

    req_t                      push_req;
    req_t                      head;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      push;
    logic                      pop;
    logic                      in_range;
    logic                      commit;
    logic                      discard;
    wire  [DEPTH-1:0]          hit;

    logic [DEPTH-1:0][WID-1:0] data_reg;
    logic [DEPTH-1:0]          valid_reg;
    logic                      done_reg;
    logic                      err_reg;
    logic [WIDTH-1:0]          done_index_reg;

    always_comb begin
        push_req       = '0;
        push_req.index = index_i;
        push_req.data  = data_i;
    end

    // Ready depends only on occupancy, never on a pop in the same cycle.
    assign write_ready_o = ~rst_i & ~fifo_full;
    assign push          = write_en_i & write_ready_o & ~clear_i;
    assign pop           = ~fifo_empty & ~clear_i & ~rst_i;
    assign in_range      = (32'(head.index) < 32'(DEPTH));
    assign commit        = pop & in_range;
    assign discard       = pop & ~in_range;

    wr_fifo #(
        .QDEPTH (QDEPTH),
        .T      (req_t)
    ) u_fifo (
        .clk       (clk_i),
        .srst      (rst_i),
        .flush     (clear_i),
        .push      (push),
        .push_data (push_req),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
        assign hit[gi] = commit && (32'(head.index) == 32'(gi));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            data_reg  <= '0;
            valid_reg <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (hit[i]) begin
                    data_reg[i]  <= head.data;
                    valid_reg[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            done_index_reg <= '0;
        end else begin
            done_reg <= commit;
            err_reg  <= discard;
            if (commit) begin
                done_index_reg <= head.index;
            end
        end
    end

    assign data_o       = data_reg;
    assign valid_o      = valid_reg;
    assign write_done_o = done_reg;
    assign write_err_o  = err_reg;
    assign done_index_o = done_index_reg;

endmodule

// File: tb/tb_demux_reg.sv
// Directed bench for demux_reg: a vector table on the default build plus
// hand-written reset, clear and out-of-range sequences (DEPTH=20 build).
module tb_demux_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Default build: WIDTH=5, DEPTH=32
    logic [4:0]         idx_a;
    logic [31:0]        din_a;
    logic               we_a, clr_a, ready_a, done_a, err_a;
    logic [31:0][31:0]  data_a;
    logic [31:0]        valid_a;
    logic [4:0]         didx_a;

    // Reduced build: WIDTH=5, DEPTH=20
    logic [4:0]         idx_b;
    logic [31:0]        din_b;
    logic               we_b, clr_b, ready_b, done_b, err_b;
    logic [19:0][31:0]  data_b;
    logic [19:0]        valid_b;
    logic [4:0]         didx_b;

    demux_reg dut_a (
        .clk_i(clk), .rst_i(rst), .index_i(idx_a), .data_i(din_a),
        .write_en_i(we_a), .write_ready_o(ready_a), .clear_i(clr_a),
        .data_o(data_a), .valid_o(valid_a), .write_done_o(done_a),
        .done_index_o(didx_a), .write_err_o(err_a)
    );

    demux_reg #(.WIDTH(5), .WID(32), .DEPTH(20), .QDEPTH(4)) dut_b (
        .clk_i(clk), .rst_i(rst), .index_i(idx_b), .data_i(din_b),
        .write_en_i(we_b), .write_ready_o(ready_b), .clear_i(clr_b),
        .data_o(data_b), .valid_o(valid_b), .write_done_o(done_b),
        .done_index_o(didx_b), .write_err_o(err_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  idx;
        logic [31:0] data;
        logic        clr;
        logic        e_done;
        logic [4:0]  e_didx;
        int          probe;
        logic [31:0] e_pdata;
        logic        e_pvalid;
        logic [31:0] e_valid;
    } vec_t;

    vec_t vecs [22];

    initial begin
        // Expected values are the outputs observed just after the edge that
        // samples the row's inputs. A write accepted at edge N commits at N+1.
        //           we  idx   data           clr done didx probe pdata          pv  valid
        vecs[0]  = '{1, 5'd3,  32'hDEADBEEF, 0, 0, 0,  3,  32'h0,         0, 32'h0};
        vecs[1]  = '{0, 5'd0,  32'h0,        0, 1, 3,  3,  32'hDEADBEEF,  1, 32'h8};
        vecs[2]  = '{0, 5'd0,  32'h0,        0, 0, 0,  3,  32'hDEADBEEF,  1, 32'h8};
        vecs[3]  = '{1, 5'd0,  32'h100,      0, 0, 0,  0,  32'h0,         0, 32'h8};
        vecs[4]  = '{1, 5'd1,  32'h101,      0, 1, 0,  0,  32'h100,       1, 32'h9};
        vecs[5]  = '{1, 5'd2,  32'h102,      0, 1, 1,  1,  32'h101,       1, 32'hB};
        vecs[6]  = '{1, 5'd3,  32'h103,      0, 1, 2,  2,  32'h102,       1, 32'hF};
        vecs[7]  = '{1, 5'd4,  32'h104,      0, 1, 3,  3,  32'h103,       1, 32'hF};
        vecs[8]  = '{1, 5'd5,  32'h105,      0, 1, 4,  4,  32'h104,       1, 32'h1F};
        vecs[9]  = '{0, 5'd0,  32'h0,        0, 1, 5,  5,  32'h105,       1, 32'h3F};
        vecs[10] = '{0, 5'd0,  32'h0,        0, 0, 0,  0,  32'h100,       1, 32'h3F};
        vecs[11] = '{1, 5'd7,  32'hAA,       0, 0, 0,  7,  32'h0,         0, 32'h3F};
        vecs[12] = '{1, 5'd7,  32'h55,       0, 1, 7,  7,  32'hAA,        1, 32'hBF};
        vecs[13] = '{0, 5'd0,  32'h0,        0, 1, 7,  7,  32'h55,        1, 32'hBF};
        vecs[14] = '{0, 5'd0,  32'h0,        0, 0, 0,  7,  32'h55,        1, 32'hBF};
        vecs[15] = '{1, 5'd9,  32'h99,       0, 0, 0,  9,  32'h0,         0, 32'hBF};
        vecs[16] = '{1, 5'd10, 32'h1010,     1, 0, 0,  9,  32'h0,         0, 32'h0};
        vecs[17] = '{0, 5'd0,  32'h0,        0, 0, 0,  10, 32'h0,         0, 32'h0};
        vecs[18] = '{0, 5'd0,  32'h0,        0, 0, 0,  9,  32'h0,         0, 32'h0};
        vecs[19] = '{1, 5'd31, 32'hFFFF0031, 0, 0, 0,  31, 32'h0,         0, 32'h0};
        vecs[20] = '{0, 5'd0,  32'h0,        0, 1, 31, 31, 32'hFFFF0031,  1, 32'h80000000};
        vecs[21] = '{0, 5'd0,  32'h0,        0, 0, 0,  3,  32'h0,         0, 32'h80000000};

        rst = 1'b1;
        idx_a = '0; din_a = '0; we_a = 1'b0; clr_a = 1'b0;
        idx_b = '0; din_b = '0; we_b = 1'b0; clr_b = 1'b0;
        tick();
        tick();

        check("rst_ready",    64'(ready_a), 64'(0));
        check("rst_valid",    64'(valid_a), 64'(0));
        check("rst_data_zero", 64'(data_a == '0), 64'(1));
        check("rst_done",     64'(done_a), 64'(0));
        check("rst_err",      64'(err_a), 64'(0));
        check("rst_didx",     64'(didx_a), 64'(0));

        rst = 1'b0;
        #1;
        check("post_rst_ready", 64'(ready_a), 64'(1));

        for (int i = 0; i < 22; i++) begin
            we_a  = vecs[i].we;
            idx_a = vecs[i].idx;
            din_a = vecs[i].data;
            clr_a = vecs[i].clr;
            tick();
            $display("row %0d: we=%0b idx=%0d data=%h clr=%0b -> ready=%0b done=%0b didx=%0d err=%0b valid=%h",
                     i, vecs[i].we, vecs[i].idx, vecs[i].data, vecs[i].clr,
                     ready_a, done_a, didx_a, err_a, valid_a);
            check($sformatf("row%0d_ready", i), 64'(ready_a), 64'(1));
            check($sformatf("row%0d_done", i), 64'(done_a), 64'(vecs[i].e_done));
            check($sformatf("row%0d_err", i), 64'(err_a), 64'(0));
            if (vecs[i].e_done)
                check($sformatf("row%0d_didx", i), 64'(didx_a), 64'(vecs[i].e_didx));
            check($sformatf("row%0d_pdata", i), 64'(data_a[vecs[i].probe]), 64'(vecs[i].e_pdata));
            check($sformatf("row%0d_pvalid", i), 64'(valid_a[vecs[i].probe]), 64'(vecs[i].e_pvalid));
            check($sformatf("row%0d_valid", i), 64'(valid_a), 64'(vecs[i].e_valid));
        end
        we_a = 1'b0; clr_a = 1'b0;
        check("clear_data_zero_except31", 64'(data_a[30:0] == '0), 64'(1));

        // Reset one cycle after three accepted writes: the third never commits.
        we_a = 1'b1; idx_a = 5'd12; din_a = 32'hC0;
        tick();
        idx_a = 5'd13; din_a = 32'hD0;
        tick();
        $display("rstseq w1: done=%0b didx=%0d", done_a, didx_a);
        check("rstseq_done12", 64'(done_a), 64'(1));
        check("rstseq_didx12", 64'(didx_a), 64'(12));
        idx_a = 5'd14; din_a = 32'hE0;
        tick();
        $display("rstseq w2: done=%0b didx=%0d", done_a, didx_a);
        check("rstseq_didx13", 64'(didx_a), 64'(13));
        check("rstseq_valid13", 64'(valid_a[13]), 64'(1));
        we_a = 1'b0; rst = 1'b1;
        tick();
        $display("rstseq rst: ready=%0b done=%0b valid=%h", ready_a, done_a, valid_a);
        check("rstseq_ready_in_rst", 64'(ready_a), 64'(0));
        check("rstseq_done_in_rst", 64'(done_a), 64'(0));
        check("rstseq_valid_in_rst", 64'(valid_a), 64'(0));
        rst = 1'b0;
        tick();
        $display("rstseq rel1: ready=%0b done=%0b valid=%h", ready_a, done_a, valid_a);
        check("rstseq_ready_rel", 64'(ready_a), 64'(1));
        check("rstseq_done_rel1", 64'(done_a), 64'(0));
        check("rstseq_valid_rel1", 64'(valid_a), 64'(0));
        tick();
        $display("rstseq rel2: done=%0b valid=%h data14=%h", done_a, valid_a, data_a[14]);
        check("rstseq_done_rel2", 64'(done_a), 64'(0));
        check("rstseq_valid_rel2", 64'(valid_a), 64'(0));
        check("rstseq_data14", 64'(data_a[14]), 64'(0));

        // DEPTH=20 build: out-of-range heads are discarded with an error pulse.
        we_b = 1'b1; idx_b = 5'd25; din_b = 32'h25;
        tick();
        we_b = 1'b0;
        tick();
        $display("oob 25: done=%0b err=%0b valid=%h", done_b, err_b, valid_b);
        check("oob25_err", 64'(err_b), 64'(1));
        check("oob25_done", 64'(done_b), 64'(0));
        check("oob25_valid", 64'(valid_b), 64'(0));
        check("oob25_data_zero", 64'(data_b == '0), 64'(1));
        tick();
        check("oob25_err_clear", 64'(err_b), 64'(0));

        we_b = 1'b1; idx_b = 5'd19; din_b = 32'h19;
        tick();
        we_b = 1'b0;
        tick();
        $display("edge 19: done=%0b didx=%0d err=%0b valid=%h", done_b, didx_b, err_b, valid_b);
        check("b19_done", 64'(done_b), 64'(1));
        check("b19_didx", 64'(didx_b), 64'(19));
        check("b19_err", 64'(err_b), 64'(0));
        check("b19_valid", 64'(valid_b), 64'(20'h80000));
        check("b19_data", 64'(data_b[19]), 64'(32'h19));

        we_b = 1'b1; idx_b = 5'd20; din_b = 32'h20;
        tick();
        we_b = 1'b0;
        tick();
        $display("oob 20: done=%0b err=%0b valid=%h", done_b, err_b, valid_b);
        check("oob20_err", 64'(err_b), 64'(1));
        check("oob20_done", 64'(done_b), 64'(0));
        check("oob20_valid", 64'(valid_b), 64'(20'h80000));
        check("oob20_data19", 64'(data_b[19]), 64'(32'h19));
        check("oob20_ready", 64'(ready_b), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
